// File: rtl/cpu_clock_controller.sv
// Slow processor clock source: free-running divided clock (RUN) or one pulse per debounced button press (STEP).
// Raw input first sampled at edge E reaches the FSM output at edge E + DEBOUNCE_CYCLES + 3.
module cpu_clock_controller #(
  parameter int HALF_PERIOD     = 62500000,
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic       clock,
  input  logic       reset_p,
  input  logic       run_mode,
  input  logic       step_btn,
  output logic       slow_clock,
  output logic       slow_tick,
  output logic       mode_led,
  output logic [7:0] tick_count
);

  localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    STEP_WAIT = 2'd0,
    STEP_HIGH = 2'd1,
    RUN       = 2'd2
  } state_t;

  // Bit 0 carries run_mode, bit 1 carries step_btn through sync and debounce.
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            db_q, db_d;
  logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic                  step_prev_q;
  logic                  step_req;
  logic                  run_db;

  state_t                state_q;
  logic [DIV_W-1:0]      div_q;
  logic                  slow_clock_q;
  logic                  slow_tick_q;
  logic                  mode_led_q;
  logic [7:0]            tick_count_q;

  // The flip fires on the mismatch cycle after the counter has reached its limit.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset_p) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      db_cnt_q    <= '0;
      step_prev_q <= 1'b0;
    end else begin
      sync1_q     <= {step_btn, run_mode};
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      db_cnt_q    <= db_cnt_d;
      step_prev_q <= db_q[1];
    end
  end

  assign run_db   = db_q[0];
  assign step_req = db_q[1] & ~step_prev_q;

  always_ff @(posedge clock) begin
    if (reset_p) begin
      state_q      <= STEP_WAIT;
      div_q        <= '0;
      slow_clock_q <= 1'b0;
      slow_tick_q  <= 1'b0;
      mode_led_q   <= 1'b0;
      tick_count_q <= '0;
    end else begin
      slow_tick_q <= 1'b0;
      case (state_q)
        STEP_WAIT: begin
          div_q        <= '0;
          slow_clock_q <= 1'b0;
          if (run_db) begin
            state_q    <= RUN;
            mode_led_q <= 1'b1;
          end else if (step_req) begin
            state_q      <= STEP_HIGH;
            slow_clock_q <= 1'b1;
            slow_tick_q  <= 1'b1;
            tick_count_q <= tick_count_q + 8'd1;
          end
        end
        STEP_HIGH: begin
          if (div_q == DIV_LAST) begin
            div_q        <= '0;
            slow_clock_q <= 1'b0;
            state_q      <= run_db ? RUN : STEP_WAIT;
            mode_led_q   <= run_db;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        RUN: begin
          // Leaving RUN forces the clock low at once; a low phase can only grow.
          if (!run_db) begin
            state_q      <= STEP_WAIT;
            mode_led_q   <= 1'b0;
            slow_clock_q <= 1'b0;
            div_q        <= '0;
          end else if (div_q == DIV_LAST) begin
            div_q        <= '0;
            slow_clock_q <= ~slow_clock_q;
            if (!slow_clock_q) begin
              slow_tick_q  <= 1'b1;
              tick_count_q <= tick_count_q + 8'd1;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: begin
          state_q      <= STEP_WAIT;
          mode_led_q   <= 1'b0;
          slow_clock_q <= 1'b0;
          div_q        <= '0;
        end
      endcase
    end
  end

  assign slow_clock = slow_clock_q;
  assign slow_tick  = slow_tick_q;
  assign mode_led   = mode_led_q;
  assign tick_count = tick_count_q;

endmodule
